// File: rtl/speed_tick_gen.sv
// Multi-channel level-scaled timebase: each channel divides clk by a period that
// shrinks with game level and emits a one-cycle tick plus a 50% square output.

module speed_tick_lane #(
    parameter int DIV_W   = 20,
    parameter int LEVEL_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LEVEL_W-1:0] lvl_i,       // already clamped to MAX_LEVEL
    input  logic [DIV_W-1:0]   base_i,
    input  logic               pause_i,
    input  logic               sync_clr_i,
    output logic               tick_o,
    output logic               sq_o
);
    localparam int PW = DIV_W + 3;

    // P = B - (B >> 3) * L, floored at 2 for an enabled channel. A result that
    // does not fit back into DIV_W bits can only be a wrap below zero, so it
    // takes the same floor.
    function automatic logic [DIV_W-1:0] period(input logic [DIV_W-1:0] b,
                                                input logic [LEVEL_W-1:0] l);
        logic [PW-1:0] p;
        p = PW'(b) - PW'(b >> 3) * PW'(l);
        if (b != '0 && (p < PW'(2) || p[PW-1:DIV_W] != '0))
            p = PW'(2);
        return p[DIV_W-1:0];
    endfunction

    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               sq_q, sq_d;
    logic [LEVEL_W-1:0] lvl_q, lvl_d;       // level in force for the current period
    logic               en_q, en_d;         // channel was enabled last cycle
    logic               en;
    logic [DIV_W-1:0]   rld_now, rld_rst;

    assign en      = (base_i != '0);
    assign rld_now = period(base_i, lvl_i) - DIV_W'(1);
    assign rld_rst = period(base_i, '0) - DIV_W'(1);

    // Next-state: reset > sync_clr > pause > disable > enable edge > count/reload.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        lvl_d  = lvl_q;
        en_d   = en_q;
        if (!reset_n) begin
            cnt_d = en ? rld_rst : '0;
            sq_d  = 1'b0;
            lvl_d = '0;
            en_d  = en;
        end else if (sync_clr_i) begin
            en_d = en;
            if (en) begin
                cnt_d = rld_now;
                sq_d  = 1'b0;
            end else begin
                cnt_d = '0;
            end
        end else if (pause_i) begin
            // everything holds; tick already defaulted low
        end else if (!en) begin
            cnt_d = '0;
            en_d  = 1'b0;
        end else if (!en_q) begin
            // freshly enabled: start a full period instead of firing on cnt == 0
            cnt_d = rld_now;
            en_d  = 1'b1;
        end else if (cnt_q == '0) begin
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            cnt_d  = rld_now;
            lvl_d  = lvl_i;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // State registers; reset is folded into the next-state logic (synchronous).
    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
        lvl_q  <= lvl_d;
        en_q   <= en_d;
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
endmodule

module speed_tick_gen #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 20,
    parameter int LEVEL_W   = 4,
    parameter int MAX_LEVEL = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [LEVEL_W-1:0]      level,
    input  logic [NUM_CH*DIV_W-1:0] base_div,
    input  logic                    pause,
    input  logic                    sync_clr,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq
);
    logic [LEVEL_W-1:0] lvl_c;

    // One shared clamp; every channel samples it at its own reload.
    always_comb begin
        lvl_c = level;
        if (level > LEVEL_W'(MAX_LEVEL))
            lvl_c = LEVEL_W'(MAX_LEVEL);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        speed_tick_lane #(
            .DIV_W   (DIV_W),
            .LEVEL_W (LEVEL_W)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .lvl_i      (lvl_c),
            .base_i     (base_div[c*DIV_W +: DIV_W]),
            .pause_i    (pause),
            .sync_clr_i (sync_clr),
            .tick_o     (tick[c]),
            .sq_o       (sq[c])
        );
    end
endmodule
